// File: rtl/sdram_burstwr_feeder_if.sv
// Bundle of the start/stream/burst-write signals between the loader side,
// the feeder (master) and the SDRAM controller plus job source (slave).
interface sdram_burstwr_feeder_if #(
  parameter int ADDR_W = 25
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0]       start_len;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              burstwr;
  logic [ADDR_W-1:0] burstwr_addr;
  logic              burstwr_ready;
  logic              burstwr_strobe;
  logic [15:0]       burstwr_data;
  logic              burstwr_done;

  modport master (
    input  start, start_addr, start_len, in_data, in_valid, burstwr_ready,
    output in_ready, busy, done, burstwr, burstwr_addr, burstwr_strobe,
           burstwr_data, burstwr_done
  );

  modport slave (
    output start, start_addr, start_len, in_data, in_valid, burstwr_ready,
    input  in_ready, busy, done, burstwr, burstwr_addr, burstwr_strobe,
           burstwr_data, burstwr_done
  );
endinterface

// File: rtl/sdram_burstwr_feeder.sv
// Splits a 32-bit input stream into 16-bit words, buffers them in a FWFT FIFO
// and feeds them to the SDRAM controller as one burstwr command per word.
//
//   state    | meaning
//   IDLE     | no job; waits for start
//   FILL     | finish when out_left==0, else issue burstwr once a word is buffered
//   WAIT_RDY | command issued; waits for burstwr_ready
//   STROBE   | data strobe cycle; word popped, address stepped
//   RELEASE  | waits for burstwr_ready to drop before the next command
module sdram_burstwr_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 25
) (
  input  logic                  controller_clk,
  input  logic                  reset_n,
  sdram_burstwr_feeder_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, FILL, WAIT_RDY, STROBE, RELEASE} state_t;

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [15:0]       in_left;
  logic [15:0]       out_left;
  logic [ADDR_W-1:0] addr;

  logic          start_ok;
  logic          xfer;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [1:0]    push_n;
  logic [15:0]   in_left_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] free_nxt;
  logic          busy_nxt;

  assign bus.burstwr_done = 1'b0;

  always_comb begin
    fifo_empty  = (count == '0);
    fifo_full   = (count == CW'(DEPTH));
    start_ok    = (state == IDLE) && bus.start && (bus.start_len != 16'd0);
    xfer        = bus.in_valid && bus.in_ready && !fifo_full;
    push_n      = 2'd0;
    if (xfer)
      push_n = (in_left == 16'd1) ? 2'd1 : 2'd2;
    pop         = (state == WAIT_RDY) && bus.burstwr_ready;
    in_left_nxt = start_ok ? bus.start_len : in_left - 16'(push_n);
    count_nxt   = count + CW'(push_n) - CW'(pop);
    free_nxt    = CW'(DEPTH) - count_nxt;
    busy_nxt    = bus.busy;
    if (start_ok)
      busy_nxt = 1'b1;
    else if ((state == FILL) && (out_left == 16'd0))
      busy_nxt = 1'b0;
  end

  // Storage is not reset; emptiness is defined purely by the pointers/count.
  always_ff @(posedge controller_clk) begin
    if (push_n != 2'd0)
      mem[wr_ptr] <= bus.in_data[31:16];
    if (push_n == 2'd2)
      mem[wr_ptr + AW'(1)] <= bus.in_data[15:0];
  end

  always_ff @(posedge controller_clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      in_left            <= '0;
      out_left           <= '0;
      addr               <= '0;
      bus.in_ready       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.burstwr        <= 1'b0;
      bus.burstwr_addr   <= '0;
      bus.burstwr_strobe <= 1'b0;
      bus.burstwr_data   <= '0;
    end else begin
      bus.done           <= 1'b0;
      bus.burstwr        <= 1'b0;
      bus.burstwr_strobe <= 1'b0;
      bus.busy           <= busy_nxt;
      // Registered from post-update occupancy so two pushes always fit.
      bus.in_ready       <= busy_nxt && (in_left_nxt != 16'd0) && (free_nxt >= CW'(2));
      in_left            <= in_left_nxt;
      count              <= count_nxt;
      if (push_n != 2'd0)
        wr_ptr <= wr_ptr + AW'(push_n);

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.start_len == 16'd0) begin
              bus.done <= 1'b1;
            end else begin
              out_left <= bus.start_len;
              addr     <= bus.start_addr;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (out_left == 16'd0) begin
            bus.done <= 1'b1;
            state    <= IDLE;
          end else if (!fifo_empty) begin
            bus.burstwr      <= 1'b1;
            bus.burstwr_addr <= addr;
            state            <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (bus.burstwr_ready) begin
            bus.burstwr_strobe <= 1'b1;
            bus.burstwr_data   <= mem[rd_ptr];
            rd_ptr             <= rd_ptr + AW'(1);
            out_left           <= out_left - 16'd1;
            addr               <= addr + ADDR_W'(1);
            state              <= STROBE;
          end
        end
        STROBE: state <= RELEASE;
        // Ready lingering after the strobe must not start another write.
        RELEASE: begin
          if (!bus.burstwr_ready)
            state <= FILL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_burstwr_feeder.sv
// Randomized bench for sdram_burstwr_feeder with a controller model and a
// word-list reference model of the expected address/data sequence.
module tb_sdram_burstwr_feeder;
  localparam int ADDR_W = 25;
  localparam int DEPTH  = 4;

  logic controller_clk = 1'b0;
  logic reset_n        = 1'b0;
  always #5 controller_clk = ~controller_clk;

  sdram_burstwr_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_burstwr_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .controller_clk(controller_clk),
    .reset_n       (reset_n),
    .bus           (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // controller model knobs
  int rdy_delay  = 3;
  int hold_after = 0;
  bit stall      = 1'b0;

  // controller model state and observations
  int pend = 0, wcnt = 0, dropping = 0, hcnt = 0, outstanding = 0;
  int n_burstwr = 0, n_done = 0, n_acc = 0, n_viol = 0;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] got_addr[$];
  logic [15:0]       got_data[$];

  // job bookkeeping
  logic [31:0]       job_words[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [15:0]       exp_data[$];
  int base_q, base_bw, base_done, base_acc, base_viol;
  int snap_acc;
  logic snap_rdy;

  always @(negedge controller_clk) begin
    if (!reset_n) begin
      bus.burstwr_ready = 1'b0;
      pend = 0; dropping = 0; outstanding = 0;
    end else begin
      if (bus.burstwr) begin
        n_burstwr++;
        if (outstanding != 0) n_viol++;
        outstanding = 1;
        cmd_addr = bus.burstwr_addr;
        pend = 1;
        wcnt = rdy_delay;
      end
      if (bus.burstwr_strobe) begin
        if (outstanding == 0 || bus.burstwr_addr !== cmd_addr) n_viol++;
        outstanding = 0;
        got_addr.push_back(bus.burstwr_addr);
        got_data.push_back(bus.burstwr_data);
        dropping = 1;
        hcnt = hold_after;
      end
      if (bus.done) n_done++;
      if (pend != 0 && !stall) begin
        if (wcnt == 0) begin bus.burstwr_ready = 1'b1; pend = 0; end
        else wcnt--;
      end
      if (dropping != 0) begin
        if (hcnt == 0) begin bus.burstwr_ready = 1'b0; dropping = 0; end
        else hcnt--;
      end
    end
  end

  always @(posedge controller_clk)
    if (reset_n && bus.in_valid && bus.in_ready) n_acc++;

  // Reference: word i is the upper then lower half of input i/2, at start+i mod 2^ADDR_W.
  function automatic void build_exp(input logic [ADDR_W-1:0] a, input int len);
    logic [31:0] w;
    longint s;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < len; i++) begin
      w = job_words[i / 2];
      exp_data.push_back((i % 2 == 0) ? w[31:16] : w[15:0]);
      s = (longint'(a) + longint'(i)) % (longint'(1) << ADDR_W);
      exp_addr.push_back(ADDR_W'(s));
    end
  endfunction

  function automatic logic [15:0] gd(input int idx);
    return (idx < got_data.size()) ? got_data[idx] : 16'hxxxx;
  endfunction

  function automatic logic [ADDR_W-1:0] ga(input int idx);
    return (idx < got_addr.size()) ? got_addr[idx] : {ADDR_W{1'bx}};
  endfunction

  function automatic void fill_words(input int len);
    job_words.delete();
    for (int i = 0; i < (len + 1) / 2; i++) job_words.push_back($urandom);
  endfunction

  task automatic run_job(input logic [ADDR_W-1:0] a, input logic [15:0] len,
                         input bit junk_after, input int busy_start_at,
                         input int stall_cycles, input int budget, output bit finished);
    int idx;
    idx       = 0;
    finished  = 1'b0;
    base_q    = got_data.size();
    base_bw   = n_burstwr;
    base_done = n_done;
    base_acc  = n_acc;
    base_viol = n_viol;
    stall     = (stall_cycles > 0);
    @(negedge controller_clk);
    bus.start = 1'b1; bus.start_addr = a; bus.start_len = len;
    @(negedge controller_clk);
    bus.start = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      if (stall_cycles > 0 && c == stall_cycles) begin
        snap_acc = n_acc - base_acc;
        snap_rdy = bus.in_ready;
        stall    = 1'b0;
      end
      bus.start = (c == busy_start_at);
      if (c == busy_start_at) begin
        bus.start_addr = 25'h0000055; bus.start_len = 16'd7;
      end
      if (idx < job_words.size()) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = job_words[idx];
        if (bus.in_valid && bus.in_ready) idx++;
      end else begin
        bus.in_valid = junk_after;
        bus.in_data  = 32'hDEADBEEF;
      end
      @(negedge controller_clk);
      if (n_done != base_done) finished = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    stall        = 1'b0;
    repeat (3) @(negedge controller_clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.start_addr = '0; bus.start_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge controller_clk);
    tests_run++;
    if ({bus.in_ready, bus.busy, bus.done, bus.burstwr, bus.burstwr_strobe, bus.burstwr_done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.in_ready, bus.busy, bus.done, bus.burstwr, bus.burstwr_strobe, bus.burstwr_done});
    end
    tests_run++;
    if (bus.burstwr_addr !== '0 || bus.burstwr_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr %h data %h required 0/0", bus.burstwr_addr, bus.burstwr_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge controller_clk);
    tests_run++;
    if ({bus.in_ready, bus.busy, bus.done, bus.burstwr, bus.burstwr_strobe} !== 5'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b required 00000",
               {bus.in_ready, bus.busy, bus.done, bus.burstwr, bus.burstwr_strobe});
    end
  endtask

  task automatic test_basic_len4();
    bit fin;
    job_words = {32'hAAAA1111, 32'hBBBB2222};
    rdy_delay = 3; hold_after = 0;
    run_job(25'h0000100, 16'd4, 1'b0, -1, 0, 400, fin);
    build_exp(25'h0000100, 4);
    tests_run++;
    if (!fin) begin tests_failed++; $display("FAIL len4_timeout: done not seen, required within 400 cycles"); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
        tests_failed++;
        $display("FAIL len4_word%0d: got %h@%h required %h@%h", i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
      end
    end
    tests_run++;
    if (n_done - base_done != 1 || bus.busy !== 1'b0 || got_data.size() - base_q != 4) begin
      tests_failed++;
      $display("FAIL len4_end: got done %0d busy %b strobes %0d required 1/0/4",
               n_done - base_done, bus.busy, got_data.size() - base_q);
    end
  endtask

  task automatic test_odd_len();
    bit fin;
    job_words = {32'h12345678, 32'h9ABCDEF0};
    rdy_delay = $urandom_range(0, 3); hold_after = $urandom_range(0, 2);
    run_job(25'h0001000, 16'd3, 1'b1, -1, 0, 400, fin);
    build_exp(25'h0001000, 3);
    tests_run++;
    if (!fin) begin tests_failed++; $display("FAIL odd_timeout: done not seen, required within 400 cycles"); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
        tests_failed++;
        $display("FAIL odd_word%0d: got %h@%h required %h@%h", i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
      end
    end
    tests_run++;
    if (n_acc - base_acc != 2 || got_data.size() - base_q != 3 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL odd_accept: got transfers %0d strobes %0d in_ready %b required 2/3/0",
               n_acc - base_acc, got_data.size() - base_q, bus.in_ready);
    end
  endtask

  task automatic test_ready_hold();
    bit fin;
    int len;
    logic [ADDR_W-1:0] a;
    len = $urandom_range(5, 10);
    a = ADDR_W'($urandom);
    fill_words(len);
    rdy_delay = $urandom_range(0, 1); hold_after = 2;
    run_job(a, 16'(len), 1'b0, -1, 0, 600, fin);
    build_exp(a, len);
    tests_run++;
    if (!fin) begin tests_failed++; $display("FAIL hold_timeout: done not seen, required within 600 cycles"); end
    tests_run++;
    if (got_data.size() - base_q != len || n_burstwr - base_bw != len || n_viol != base_viol) begin
      tests_failed++;
      $display("FAIL hold_count: got strobes %0d cmds %0d violations %0d required %0d/%0d/0",
               got_data.size() - base_q, n_burstwr - base_bw, n_viol - base_viol, len, len);
    end
    for (int i = 0; i < len; i++) begin
      tests_run++;
      if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
        tests_failed++;
        $display("FAIL hold_word%0d: got %h@%h required %h@%h", i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_stall_depth();
    bit fin;
    fill_words(8);
    rdy_delay = 1; hold_after = 0;
    run_job(25'h0020000, 16'd8, 1'b0, -1, 30, 600, fin);
    build_exp(25'h0020000, 8);
    tests_run++;
    if (snap_acc != 2 || snap_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_backpressure: got transfers %0d in_ready %b required 2/0", snap_acc, snap_rdy);
    end
    tests_run++;
    if (!fin || got_data.size() - base_q != 8) begin
      tests_failed++;
      $display("FAIL stall_complete: got done %b strobes %0d required 1/8", fin, got_data.size() - base_q);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
        tests_failed++;
        $display("FAIL stall_word%0d: got %h@%h required %h@%h", i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit fin;
    fill_words(2);
    rdy_delay = 2; hold_after = 1;
    run_job(25'h1FFFFFF, 16'd2, 1'b0, -1, 0, 300, fin);
    tests_run++;
    if (!fin || ga(base_q) !== 25'h1FFFFFF || ga(base_q + 1) !== 25'h0000000) begin
      tests_failed++;
      $display("FAIL addr_wrap: got done %b addrs %h,%h required 1, 1ffffff,0000000", fin, ga(base_q), ga(base_q + 1));
    end
    tests_run++;
    if (gd(base_q) !== job_words[0][31:16] || gd(base_q + 1) !== job_words[0][15:0]) begin
      tests_failed++;
      $display("FAIL wrap_data: got %h,%h required %h,%h", gd(base_q), gd(base_q + 1), job_words[0][31:16], job_words[0][15:0]);
    end
  endtask

  task automatic test_start_busy_and_zero();
    bit fin;
    int bw0;
    fill_words(6);
    rdy_delay = 1; hold_after = 0;
    run_job(25'h0000200, 16'd6, 1'b0, 5, 0, 500, fin);
    build_exp(25'h0000200, 6);
    tests_run++;
    if (!fin || got_data.size() - base_q != 6 || n_done - base_done != 1) begin
      tests_failed++;
      $display("FAIL busy_start_count: got done %b strobes %0d dones %0d required 1/6/1",
               fin, got_data.size() - base_q, n_done - base_done);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
        tests_failed++;
        $display("FAIL busy_start_word%0d: got %h@%h required %h@%h", i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
      end
    end
    bw0 = n_burstwr;
    @(negedge controller_clk);
    bus.start = 1'b1; bus.start_addr = 25'h0000300; bus.start_len = 16'd0;
    @(negedge controller_clk);
    bus.start = 1'b0;
    #1;
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_done: got done %b busy %b required 1/0", bus.done, bus.busy);
    end
    repeat (4) @(negedge controller_clk);
    tests_run++;
    if (bus.done !== 1'b0 || n_burstwr != bw0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_after: got done %b cmds %0d busy %b required 0/0/0", bus.done, n_burstwr - bw0, bus.busy);
    end
  endtask

  task automatic test_random_jobs();
    bit fin;
    int len;
    logic [ADDR_W-1:0] a;
    for (int j = 0; j < 6; j++) begin
      len = $urandom_range(1, 12);
      a = (j == 0) ? 25'h1FFFFFA : ADDR_W'($urandom);
      fill_words(len);
      rdy_delay = $urandom_range(0, 4); hold_after = $urandom_range(0, 2);
      run_job(a, 16'(len), 1'($urandom_range(0, 1)), -1, 0, 800, fin);
      build_exp(a, len);
      tests_run++;
      if (!fin || got_data.size() - base_q != len || n_viol != base_viol || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand%0d_job: got done %b strobes %0d violations %0d busy %b required 1/%0d/0/0",
                 j, fin, got_data.size() - base_q, n_viol - base_viol, bus.busy, len);
      end
      for (int i = 0; i < len; i++) begin
        tests_run++;
        if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
          tests_failed++;
          $display("FAIL rand%0d_word%0d: got %h@%h required %h@%h", j, i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bit fin;
    fill_words(8);
    rdy_delay = 2; hold_after = 0;
    run_job(25'h0004000, 16'd8, 1'b0, -1, 0, 8, fin);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.busy, bus.done, bus.burstwr, bus.burstwr_strobe} !== 5'b0 ||
        bus.burstwr_addr !== '0 || bus.burstwr_data !== '0) begin
      tests_failed++;
      $display("FAIL midjob_reset: got flags %b addr %h data %h required 0",
               {bus.in_ready, bus.busy, bus.done, bus.burstwr, bus.burstwr_strobe}, bus.burstwr_addr, bus.burstwr_data);
    end
    repeat (2) @(negedge controller_clk);
    reset_n = 1'b1;
    @(negedge controller_clk);
    fill_words(4);
    run_job(25'h0005000, 16'd4, 1'b0, -1, 0, 400, fin);
    build_exp(25'h0005000, 4);
    tests_run++;
    if (!fin || got_data.size() - base_q != 4) begin
      tests_failed++;
      $display("FAIL after_reset_job: got done %b strobes %0d required 1/4", fin, got_data.size() - base_q);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (gd(base_q + i) !== exp_data[i] || ga(base_q + i) !== exp_addr[i]) begin
        tests_failed++;
        $display("FAIL after_reset_word%0d: got %h@%h required %h@%h", i, gd(base_q + i), ga(base_q + i), exp_data[i], exp_addr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_len4();
    test_odd_len();
    test_ready_hold();
    test_stall_depth();
    test_addr_wrap();
    test_start_busy_and_zero();
    test_random_jobs();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sdram_burstwr_feeder.md
Name: sdram_burstwr_feeder

Overview:
- Upstream feeder for the SDRAM controller's burst-write port. Accepts a 32-bit stream from the bridge/loader side, splits each 32-bit input into 16-bit words, and buffers the words in a FIFO.
- Issues one burstwr command per 16-bit word to the controller and steps the address. Signals completion once the programmed word count has been written.

Parameters:
- DEPTH, 16, FIFO depth in 16-bit words; power of 2, minimum 4.
- ADDR_W, 25, SDRAM word address width; matches the controller's burstwr_addr.

Ports:
- controller_clk  in  1  controller clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; loads start_addr/start_len. Ignored while busy.
- start_addr  in  25  first 16-bit word address.
- start_len  in  16  number of 16-bit words to write. 0 means no operation.
- in_data  in  32  input data; [31:16] is written first, then [15:0].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  feeder accepts in_data this cycle.
- busy  out  1  a job is active.
- done  out  1  one-cycle pulse when the last word has been strobed.
- burstwr  out  1  one-cycle command pulse to the controller.
- burstwr_addr  out  25  address; held stable from the burstwr pulse until the strobe.
- burstwr_ready  in  1  controller is ready to take a data word.
- burstwr_strobe  out  1  one-cycle data strobe.
- burstwr_data  out  16  data word; valid with burstwr_strobe.
- burstwr_done  out  1  tied 0; reserved.

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, burstwr=0, burstwr_addr=0, burstwr_strobe=0, burstwr_data=0, burstwr_done=0. Reset empties the FIFO and clears all counters.
- Reset is asserted together with the controller reset; reset mid-job is not recoverable on its own.
- Counters:
  - in_left (16b): words still to accept.
  - out_left (16b): words still to strobe.
  - addr (ADDR_W): current word address.
- start handling:
  - start with start_len≠0 in IDLE → next cycle busy=1, in_left=out_left=start_len, addr=start_addr.
  - start with start_len=0 → done pulses the next cycle; busy stays 0.
  - start while busy → ignored.
- Input side:
  - in_ready=1 iff busy, in_left>0, and FIFO free≥2.
  - Transfer occurs when in_valid & in_ready. It pushes [31:16], then [15:0], and decrements in_left by 2.
  - If in_left==1, only [31:16] is pushed, [15:0] is discarded, and in_left becomes 0.
  - in_ready is registered from the post-update state, so no FIFO overflow is possible.
- FIFO: synchronous, DEPTH entries, with full/empty flags and first-word-fall-through.
- Output FSM:
  - IDLE: waits for an accepted start, then goes to FILL.
  - FILL: if out_left==0 → done=1, busy=0, go to IDLE. Else if FIFO non-empty → burstwr=1 for one cycle, burstwr_addr=addr, go to WAIT_RDY.
  - WAIT_RDY: waits for burstwr_ready=1. No timeout.
  - STROBE: burstwr_strobe=1 for exactly one cycle, burstwr_data=FIFO head. Pops the FIFO, decrements out_left, does addr+1, goes to RELEASE.
    - Address wraps modulo 2^ADDR_W.
    - burstwr_addr keeps its value until the next burstwr.
  - RELEASE: waits for burstwr_ready==0. The controller's ready may stay high up to 2 cycles after the strobe; those cycles must never produce a second strobe. Then go to FILL.
- Throughput: at most one word per controller write cycle. The FSM never has more than one command outstanding.
- Input and output sides run concurrently. The FIFO may be simultaneously pushed and popped in the same cycle.
- busy falls in the same cycle that done pulses.

Test Plan:
- start_addr=0x0000100, len=4; inputs 0xAAAA1111, 0xBBBB2222; controller model asserts ready 3 cycles after each burstwr → strobes carry AAAA,1111,BBBB,2222 at addresses 0x100–0x103; done pulses once; busy returns to 0.
- len=3; inputs 0x12345678, 0x9ABCDEF0 → words 1234,5678,9ABC written; DEF0 discarded; in_ready stays 0 after the second transfer.
- Controller holds ready high 2 cycles after each strobe → exactly one strobe per burstwr; total strobes = len.
- DEPTH=4 with the controller stalled (ready=0) → in_ready drops after 2 inputs; no data is lost after release.
- start_addr=0x1FFFFFF, len=2 → addresses 0x1FFFFFF then 0x0000000.
- start while busy, and start with len=0 → the busy start is ignored; len=0 gives done the next cycle with no burstwr. Reset mid-job → all outputs return to 0 and the FIFO is empty.
